// File: rtl/wb_slave_regs.sv
// wb_slave_regs: Wishbone classic slave exposing NUM_REGS 32-bit read/write registers with programmable wait states.
//   Clock/reset : wb_clk (rising edge), wb_rst (synchronous, active-high)
//   Slave side  : wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i/wb_bte_i (ignored)
//                 wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o (tied 0)
//   Side output : ctrl_o, live copy of register 0
//   Build option: define WB_SLAVE_ERR_EN to terminate misses with wb_err_o instead of an empty ack.
//   dw is expected to be 32: each register is four byte lanes selected by wb_sel_i.
module wb_slave_regs #(
  parameter int dw = 32,
  parameter int aw = 32,
  parameter logic [aw-1:0] BASE_ADDR = 32'h0000_1000,
  parameter int NUM_REGS = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic [aw-1:0] wb_adr_i,
  input  logic [dw-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [dw-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_rty_o,
  output logic [dw-1:0] ctrl_o
);
  localparam int IW = $clog2(NUM_REGS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t          state, state_n;
  logic [2:0]      cnt;
  logic [aw-1:0]   adr_q, acc_adr;
  logic [dw-1:0]   dat_q, acc_dat;
  logic [3:0]      sel_q, acc_sel;
  logic            we_q, acc_we, req, go, hit;
  logic [IW-1:0]   idx;
  logic [dw-1:0]   regs [NUM_REGS];
  logic            unused;
  // With zero wait states the access completes on the sampling edge, so the
  // live bus inputs are used in IDLE and the latched copy afterwards.
  assign acc_adr = state == IDLE ? wb_adr_i : adr_q;
  assign acc_dat = state == IDLE ? wb_dat_i : dat_q;
  assign acc_sel = state == IDLE ? wb_sel_i : sel_q;
  assign acc_we  = state == IDLE ? wb_we_i  : we_q;
  assign req     = wb_cyc_i && wb_stb_i;
  // BASE_ADDR is aligned to the window size, so a hit is an upper-bit match.
  assign hit     = acc_adr[1:0] == 2'b00 && acc_adr[aw-1:IW+2] == BASE_ADDR[aw-1:IW+2];
  assign idx     = acc_adr[IW+1:2];
  assign ctrl_o  = regs[0];
  assign wb_rty_o = 1'b0;
  assign unused  = ^{wb_cti_i, wb_bte_i};
  always_comb begin
    go = 1'b0;
    state_n = IDLE;
    go = (state == IDLE && req && WAIT_STATES == 0) || (state == WAIT && wb_cyc_i && cnt == 3'd0);
    state_n = go ? RESP
            : (state == IDLE && req) || (state == WAIT && wb_cyc_i) ? WAIT
            : IDLE;
  end
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state <= IDLE;
      cnt <= 3'd0;
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      we_q <= 1'b0;
      wb_dat_o <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state <= state_n;
      cnt <= state_n == WAIT ? (state == IDLE ? 3'(WAIT_STATES - 1) : cnt - 3'd1) : 3'd0;
      if (state == IDLE && req) begin
        adr_q <= wb_adr_i;
        dat_q <= wb_dat_i;
        sel_q <= wb_sel_i;
        we_q <= wb_we_i;
      end
`ifdef WB_SLAVE_ERR_EN
      wb_ack_o <= go && hit;
      wb_err_o <= go && !hit;
`else
      wb_ack_o <= go;
      wb_err_o <= 1'b0;
`endif
      wb_dat_o <= go && !acc_we && hit ? regs[idx] : '0;
      if (go && acc_we && hit)
        for (int b = 0; b < 4; b++)
          if (acc_sel[b]) regs[idx][8*b +: 8] <= acc_dat[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_wb_slave_regs.sv
// tb_wb_slave_regs: checks three wb_slave_regs instances (0, 1 and 3 wait states) against a register-array model.
module tb_wb_slave_regs;
  localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef WB_SLAVE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam bit MA = !ERR_EN;
  localparam bit ME = ERR_EN;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic [31:0] dat = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0;
  logic [2:0]  cti = '0;
  logic [1:0]  bte = '0;
  logic [2:0]  cyc = '0;
  logic [2:0]  stb = '0;
  logic [2:0]  ack, err, rty;
  logic [31:0] dat_o [3];
  logic [31:0] ctrl [3];

  logic [31:0] m [3][16];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_slave_regs #(.WAIT_STATES(0)) u0 (
    .wb_clk(clk), .wb_rst(rst), .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel), .wb_we_i(we),
    .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(dat_o[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0]), .wb_rty_o(rty[0]), .ctrl_o(ctrl[0]));
  wb_slave_regs #(.WAIT_STATES(1)) u1 (
    .wb_clk(clk), .wb_rst(rst), .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel), .wb_we_i(we),
    .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(dat_o[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1]), .wb_rty_o(rty[1]), .ctrl_o(ctrl[1]));
  wb_slave_regs #(.WAIT_STATES(3)) u2 (
    .wb_clk(clk), .wb_rst(rst), .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel), .wb_we_i(we),
    .wb_cyc_i(cyc[2]), .wb_stb_i(stb[2]), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(dat_o[2]), .wb_ack_o(ack[2]), .wb_err_o(err[2]), .wb_rty_o(rty[2]), .ctrl_o(ctrl[2]));

  function automatic int ws_of(input int k);
    return k == 0 ? 0 : k == 1 ? 1 : 3;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return (a % 4) == 0 && a >= BASE && a < BASE + 64;
  endfunction

  function automatic void model_write(input int k, input bit w, input logic [31:0] a, d, input logic [3:0] s);
    if (w && model_hit(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) m[k][(a - BASE) / 4][8*b +: 8] = d[8*b +: 8];
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 16; i++) m[k][i] = '0;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One classic access on instance k; stb is held through the edge that ends the ack cycle.
  task automatic do_access(input int k, input bit w, input logic [31:0] a, d, input logic [3:0] s,
                           input bit e_ack, e_err, input logic [31:0] e_dat, input string tag);
    int n;
    adr = a; dat = d; sel = s; we = w; cyc[k] = 1'b1; stb[k] = 1'b1;
    n = 0;
    do begin
      @(posedge clk); n++; @(negedge clk);
    end while (!(ack[k] || err[k]) && n < 20);
    check({tag, " latency"}, 32'(n), 32'(ws_of(k) + 1));
    check({tag, " ack"}, {31'b0, ack[k]}, {31'b0, e_ack});
    check({tag, " err"}, {31'b0, err[k]}, {31'b0, e_err});
    check({tag, " rdata"}, dat_o[k], e_dat);
    @(posedge clk); @(negedge clk);
    check({tag, " one-cycle"}, {30'b0, ack[k], err[k]}, 32'd0);
    check({tag, " rdata idle"}, dat_o[k], 32'd0);
    check({tag, " ctrl"}, ctrl[k], m[k][0]);
    cyc[k] = 1'b0; stb[k] = 1'b0; we = 1'b0;
  endtask

  task automatic watch_quiet(input int k, input int cycles, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); @(negedge clk);
      if (ack[k] || err[k]) seen = 1'b1;
    end
    check({tag, " no termination"}, {31'b0, seen}, 32'd0);
  endtask

  typedef struct {
    bit we; logic [31:0] a; logic [31:0] d; logic [3:0] s; bit ack; bit err; logic [31:0] rd;
  } vec_t;
  vec_t tv [15];

  initial begin
    logic [31:0] a, d, e_dat;
    logic [3:0]  s;
    bit          w, h;
    int          r, ix;
    tv[0]  = '{1'b1, 32'h1004, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 32'h0};
    tv[1]  = '{1'b0, 32'h1004, 32'h0,        4'hF, 1'b1, 1'b0, 32'hDEADBEEF};
    tv[2]  = '{1'b1, 32'h1000, 32'h11223344, 4'hF, 1'b1, 1'b0, 32'h0};
    tv[3]  = '{1'b1, 32'h1000, 32'hAABBCCDD, 4'h5, 1'b1, 1'b0, 32'h0};
    tv[4]  = '{1'b0, 32'h1000, 32'h0,        4'h0, 1'b1, 1'b0, 32'h11BB33DD};
    tv[5]  = '{1'b0, 32'h1040, 32'h0,        4'hF, MA,   ME,   32'h0};
    tv[6]  = '{1'b0, 32'h1002, 32'h0,        4'hF, MA,   ME,   32'h0};
    tv[7]  = '{1'b1, 32'h1040, 32'h12345678, 4'hF, MA,   ME,   32'h0};
    tv[8]  = '{1'b1, 32'h1006, 32'h12345678, 4'hF, MA,   ME,   32'h0};
    tv[9]  = '{1'b1, 32'h1004, 32'h55555555, 4'h0, 1'b1, 1'b0, 32'h0};
    tv[10] = '{1'b0, 32'h1004, 32'h0,        4'h3, 1'b1, 1'b0, 32'hDEADBEEF};
    tv[11] = '{1'b0, 32'h103C, 32'h0,        4'hF, 1'b1, 1'b0, 32'h0};
    tv[12] = '{1'b1, 32'h103C, 32'hFFFFFFFF, 4'h8, 1'b1, 1'b0, 32'h0};
    tv[13] = '{1'b0, 32'h103C, 32'h0,        4'hF, 1'b1, 1'b0, 32'hFF000000};
    tv[14] = '{1'b0, 32'h0FFC, 32'h0,        4'hF, MA,   ME,   32'h0};
    model_clear();

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset ack/err/rty %0d", k), {29'b0, ack[k], err[k], rty[k]}, 32'd0);
      check($sformatf("reset rdata %0d", k), dat_o[k], 32'd0);
      check($sformatf("reset ctrl %0d", k), ctrl[k], 32'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      model_write(1, tv[i].we, tv[i].a, tv[i].d, tv[i].s);
      do_access(1, tv[i].we, tv[i].a, tv[i].d, tv[i].s, tv[i].ack, tv[i].err, tv[i].rd, $sformatf("vec%0d", i));
    end
    check("vec ctrl after lane write", ctrl[1], 32'h11BB33DD);

    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 60; i++) begin
        r = $urandom_range(0, 9);
        ix = $urandom_range(0, 15);
        a = r < 7 ? BASE + 32'(4 * ix)
          : r == 7 ? BASE + 32'(4 * ix) + 32'($urandom_range(1, 3))
          : r == 8 ? BASE + 64 + 32'(4 * $urandom_range(0, 63))
          : BASE - 32'(4 * $urandom_range(1, 64));
        w = 1'($urandom_range(0, 1));
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        h = model_hit(a);
        e_dat = (!w && h) ? m[k][(a - BASE) / 4] : 32'd0;
        model_write(k, w, a, d, s);
        do_access(k, w, a, d, s, ERR_EN ? h : 1'b1, ERR_EN ? !h : 1'b0, e_dat, $sformatf("rand%0d.%0d", k, i));
      end

    adr = 32'h1008; dat = 32'hCAFEF00D; sel = 4'hF; we = 1'b1; cyc[2] = 1'b1; stb[2] = 1'b1;
    @(posedge clk); @(negedge clk);
    cyc[2] = 1'b0; stb[2] = 1'b0; we = 1'b0;
    watch_quiet(2, 8, "abort");
    do_access(2, 1'b0, 32'h1008, 32'h0, 4'hF, 1'b1, 1'b0, m[2][2], "abort readback");
    model_write(2, 1'b1, 32'h1018, 32'h0BADF00D, 4'hF);
    do_access(2, 1'b1, 32'h1018, 32'h0BADF00D, 4'hF, 1'b1, 1'b0, 32'h0, "post-abort write");

    model_write(2, 1'b1, 32'h1000, 32'h13572468, 4'hF);
    do_access(2, 1'b1, 32'h1000, 32'h13572468, 4'hF, 1'b1, 1'b0, 32'h0, "pre-reset ctrl write");
    check("pre-reset ctrl", ctrl[2], 32'h13572468);
    adr = 32'h1008; dat = 32'h87654321; sel = 4'hF; we = 1'b1; cyc[2] = 1'b1; stb[2] = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; cyc[2] = 1'b0; stb[2] = 1'b0; we = 1'b0;
    check("reset-in-wait ack/err", {30'b0, ack[2], err[2]}, 32'd0);
    model_clear();
    watch_quiet(2, 6, "reset-in-wait");
    for (int k = 0; k < 3; k++) check($sformatf("post-reset ctrl %0d", k), ctrl[k], 32'd0);
    do_access(2, 1'b0, 32'h1008, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0, "post-reset reg2");
    do_access(2, 1'b0, 32'h1000, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0, "post-reset reg0");
    do_access(0, 1'b0, 32'h1004, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0, "post-reset other");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_slave_regs.md
WB_SLAVE_REGS -- requirements
Module: wb_slave_regs

Interface
REQ-001 The block SHALL have parameter dw, default 32, data width.
REQ-002 The block SHALL have parameter aw, default 32, address width.
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h0000_1000, byte base address, aligned to 4*NUM_REGS.
REQ-004 The block SHALL have parameter NUM_REGS, default 16, power of two in 2..64, number of 32-bit registers.
REQ-005 The block SHALL have parameter WAIT_STATES, default 1, range 0..7, extra cycles before ack.
REQ-006 The block SHALL have these ports:
- wb_clk  in  1  sole clock, rising edge.
- wb_rst  in  1  reset, synchronous, active-high.
- wb_adr_i  in  aw  byte address.
- wb_dat_i  in  dw  write data.
- wb_sel_i  in  4  byte lane enables.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  cycle valid.
- wb_stb_i  in  1  strobe.
- wb_cti_i  in  3  cycle type, ignored (classic only).
- wb_bte_i  in  2  burst type, ignored.
- wb_dat_o  out  dw  read data.
- wb_ack_o  out  1  normal termination.
- wb_err_o  out  1  error termination.
- wb_rty_o  out  1  retry, constant 0.
- ctrl_o  out  dw  continuous copy of register 0.

Function
REQ-007 The FSM SHALL have states IDLE, WAIT, RESP; all outputs SHALL be registered.
REQ-008 In IDLE with wb_cyc_i & wb_stb_i = 1: latch address, data, sel and we; go to WAIT if WAIT_STATES > 0 (counter loaded with WAIT_STATES-1), else to RESP.
REQ-009 WAIT SHALL decrement the counter each cycle and go to RESP when it is 0 (ack/err asserted WAIT_STATES+1 cycles after stb is first sampled).
REQ-010 On entry to RESP: exactly one of wb_ack_o/wb_err_o SHALL be 1 for exactly one cycle; RESP SHALL always return to IDLE, ignoring stb, so that one strobe yields one access.
REQ-011 Hit: adr[1:0] = 0 and adr within BASE_ADDR .. BASE_ADDR+4*NUM_REGS-1; register index = adr[log2(NUM_REGS)+1:2].
REQ-012 Hit write: on the edge entering RESP, update only byte lanes with sel=1; sel=0 in every lane SHALL ack without changing the register.
REQ-013 Hit read: wb_dat_o SHALL hold the full register (sel ignored) during the ack cycle and 0 in all other cycles.
REQ-014 Miss: behaviour per REQ-019/REQ-020; a miss SHALL never modify any register.
REQ-015 If wb_cyc_i drops in WAIT: return to IDLE next edge, no ack/err, no write (abort).
REQ-016 A write on the edge entering RESP SHALL make ctrl_o show the new register 0 value in the following cycle.

Reset
REQ-017 When wb_rst=1 at a clock edge: FSM to IDLE, counter 0, all registers 0, wb_dat_o=0, wb_ack_o=0, wb_err_o=0, ctrl_o=0.
REQ-018 Reset during WAIT or RESP SHALL take priority: the pending access is dropped, no write, no ack/err.

Configuration
REQ-019 With WB_SLAVE_ERR_EN defined, a miss SHALL end with wb_err_o=1 and wb_ack_o=0 (same latency as a hit).
REQ-020 Without WB_SLAVE_ERR_EN, a miss SHALL end with wb_ack_o=1, read data 0 and the write discarded; wb_err_o SHALL be constant 0.

Verification
REQ-021 WAIT_STATES=1: write 32'hDEADBEEF, sel=4'hF, to 32'h1004, then read it back -> ack 2 cycles after stb, read data 32'hDEADBEEF, one-cycle ack each time.
REQ-022 Reg 0 = 32'h11223344; write 32'hAABBCCDD with sel=4'b0101 -> reg 0 and ctrl_o = 32'h11BB33DD.
REQ-023 Read 32'h1040 (out of range) and 32'h1002 (misaligned) -> with WB_SLAVE_ERR_EN: err pulse, no ack; without it: ack with data 0; all registers unchanged.
REQ-024 WAIT_STATES=3: drop cyc one cycle after stb during a write -> no ack/err, register unchanged, next access served normally.
REQ-025 Assert reset during WAIT of a write to 32'h1008 -> no ack, all registers 0 and ctrl_o=0 after reset.
REQ-026 WAIT_STATES=0: back-to-back master accesses with stb held one cycle past ack -> exactly one ack per access, ack 1 cycle after stb.
